// File: rtl/iir_sample_capture.sv
// -----------------------------------------------------------------------------
// iir_sample_capture
//   Output-side sink for the iir_N filter. A free-running clock divider
//   produces one sample tick every SAMPLE_DIV cycles while enabled; on each
//   tick the filter output y is pushed into a circular FIFO. Samples leave
//   through a first-word-fall-through valid/ready read port.
//
// Ports
//   clk         in   clock, all state updates on posedge
//   rst         in   synchronous reset, active-high
//   en          in   enable for the sample divider / capture
//   y           in   signed filter output sampled on each tick
//   sample_tick out  high on the cycle y is captured
//   rd_valid    out  FIFO non-empty
//   rd_ready    in   consumer accepts rd_data this cycle
//   rd_data     out  head-of-FIFO sample (meaningful while rd_valid)
//   level       out  occupancy 0..DEPTH
//   full        out  level == DEPTH
//   overflow    out  sticky flag: a tick arrived while full with no pop
//   clr_ovf     in   clears overflow (a drop in the same cycle wins)
//   drop_cnt    out  saturating count of discarded samples
//
// Read handshake: a pop happens at a rising edge exactly when rd_valid and
// rd_ready are both high in the preceding cycle. rd_data and rd_valid are
// driven from registered state only, so they never depend on rd_ready, and
// rd_data holds steady while rd_valid is high and rd_ready is low.
// -----------------------------------------------------------------------------
module iir_sample_capture #(
  parameter int BITWIDTH   = 32,
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 4,
  parameter int DROPW      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [BITWIDTH-1:0]   y,
  output logic                         sample_tick,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic signed [BITWIDTH-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         overflow,
  input  logic                         clr_ovf,
  output logic [DROPW-1:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [CW-1:0]    DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [DROPW-1:0] DROP_MAX = '1;

  // Registered state
  logic [CW-1:0]          div_cnt_q,  div_cnt_d;
  logic [AW-1:0]          wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q,   rd_ptr_d;
  logic [LW-1:0]          level_q,    level_d;
  logic                   overflow_q, overflow_d;
  logic [DROPW-1:0]       drop_cnt_q, drop_cnt_d;

  // Sample storage; deliberately not reset.
  logic [BITWIDTH-1:0]    mem_q [DEPTH];

  // Per-cycle events
  logic tick;
  logic is_full;
  logic is_empty;
  logic pop;
  logic push;
  logic drop;

  assign tick     = en && (div_cnt_q == DIV_LAST);
  assign is_full  = (level_q == LVL_FULL);
  assign is_empty = (level_q == '0);
  assign pop      = !is_empty && rd_ready;
  // When full, a same-cycle pop frees the slot the tick needs. Because
  // wr_ptr == rd_ptr when full, the write lands in the slot being read out,
  // which is fine: the read sees the old contents this cycle.
  assign push     = tick && (!is_full || pop);
  assign drop     = tick && is_full && !pop;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    // Divider: held at zero while disabled so the first tick after enabling
    // lands SAMPLE_DIV-1 cycles later.
    if (!en) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end

    // Set has priority over clear so a drop is never hidden.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    if (drop && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Write is gated by !rst so a tick in the reset cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= y;
    end
  end

  assign sample_tick = tick;
  assign rd_valid    = !is_empty;
  assign rd_data     = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign full        = is_full;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
